// File: rtl/font_pkg.sv
// Shared constants for the font ROM arbiter and its round-robin picker.
//   N_REQ  : number of requesters sharing the font ROM read port
//   AW, DW : ROM address / data widths (address = {char_code, row})
//   REQ_*  : requester index assignment
//   PTR_W  : width of a requester index / round-robin pointer
package font_pkg;
  localparam int N_REQ  = 4;
  localparam int AW     = 11;
  localparam int DW     = 8;
  localparam int CHAR_W = 7;
  localparam int ROW_W  = 4;
  localparam int PTR_W  = $clog2(N_REQ);

  localparam int REQ_HOUR  = 0;
  localparam int REQ_DATE  = 1;
  localparam int REQ_TIMER = 2;
  localparam int REQ_TEXT  = 3;

  // One-hot vector with only bit idx set.
  function automatic logic [N_REQ-1:0] idx_onehot(input logic [PTR_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select.
//   i_pending : pending request vector
//   i_ptr     : index that has first priority this cycle
//   o_any     : at least one request pending
//   o_sel     : first pending index at or after i_ptr, wrapping modulo N_REQ
module rr_picker
  import font_pkg::*;
(
  input  logic [N_REQ-1:0] i_pending,
  input  logic [PTR_W-1:0] i_ptr,
  output logic             o_any,
  output logic [PTR_W-1:0] o_sel
);

  logic [PTR_W-1:0] w_idx;

  // Scan from the farthest offset down to offset 0 so that the closest
  // pending index to the pointer is the last one written and wins.
  always_comb begin
    o_any = |i_pending;
    o_sel = '0;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % N_REQ);
      if (i_pending[w_idx]) o_sel = w_idx;
    end
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM read port among the text renderers
// (hour, date, timer digits and static label text).
//   clk, reset : single clock, synchronous active-high reset
//   req        : per-requester one-cycle read request
//   req_addr   : flattened addresses, requester i at [i*AW +: AW]
//   pending    : request i captured and not yet issued
//   rom_en     : registered ROM read enable
//   rom_addr   : registered ROM address
//   rom_data   : ROM output, valid the cycle after rom_en
//   rd_valid   : one-hot strobe, bit i marks rd_data as requester i's
//   rd_data    : returned glyph row, holds its last value between strobes
//   overrun    : sticky, a request arrived while the previous one was pending
//
// Handshake: there is no ready. A requester raises req[i] for one cycle per
// read; it is accepted when pending[i] is low at that edge and dropped (and
// overrun[i] set) otherwise. The answer comes back as a single-cycle
// rd_valid[i] strobe that cannot be stalled; at most one bit is ever high.
module font_rom_arbiter
  import font_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  output logic [N_REQ-1:0]    pending,
  output logic                rom_en,
  output logic [AW-1:0]       rom_addr,
  input  logic [DW-1:0]       rom_data,
  output logic [N_REQ-1:0]    rd_valid,
  output logic [DW-1:0]       rd_data,
  output logic [N_REQ-1:0]    overrun
);

  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] r_overrun;
  logic [AW-1:0]    r_addr_q [N_REQ];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_tag;
  logic [PTR_W-1:0] r_ret_tag;
  logic             r_rom_en;
  logic             r_ret_vld;
  logic [AW-1:0]    r_rom_addr;
  logic [DW-1:0]    r_rd_hold;

  logic             w_any;
  logic [PTR_W-1:0] w_sel;
  logic [PTR_W-1:0] w_next_ptr;
  logic [N_REQ-1:0] w_capture;
  logic [N_REQ-1:0] w_drop;
  logic [N_REQ-1:0] w_issue;

  rr_picker u_picker (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .o_any     (w_any),
    .o_sel     (w_sel)
  );

  // Capture and overrun both look at registered pending, so a request in
  // the same cycle its predecessor is issued still counts as an overrun,
  // and a bit is never captured and issued on the same edge.
  always_comb begin
    w_capture  = req & ~r_pending;
    w_drop     = req & r_pending;
    w_issue    = w_any ? idx_onehot(w_sel) : '0;
    w_next_ptr = (w_sel == PTR_W'(N_REQ - 1)) ? '0 : w_sel + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending  <= '0;
      r_overrun  <= '0;
      r_ptr      <= '0;
      r_tag      <= '0;
      r_ret_tag  <= '0;
      r_rom_en   <= 1'b0;
      r_ret_vld  <= 1'b0;
      r_rom_addr <= '0;
      r_rd_hold  <= '0;
    end else begin
      r_pending <= (r_pending & ~w_issue) | w_capture;
      r_overrun <= r_overrun | w_drop;
      r_rom_en  <= w_any;
      if (w_any) begin
        r_rom_addr <= r_addr_q[w_sel];
        r_tag      <= w_sel;
        r_ptr      <= w_next_ptr;
      end
      // The ROM answers one cycle after rom_en; r_ret_vld marks that cycle
      // and clearing it on reset discards any read already in flight.
      r_ret_vld <= r_rom_en;
      r_ret_tag <= r_tag;
      r_rd_hold <= rd_data;
    end
  end

  // Address holding registers need no reset: they are only read while the
  // matching pending bit is set, which implies a capture has happened.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (w_capture[i]) r_addr_q[i] <= req_addr[i*AW +: AW];
    end
  end

  assign pending  = r_pending;
  assign overrun  = r_overrun;
  assign rom_en   = r_rom_en;
  assign rom_addr = r_rom_addr;
  assign rd_valid = r_ret_vld ? idx_onehot(r_ret_tag) : '0;
  assign rd_data  = r_ret_vld ? rom_data : r_rd_hold;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Self-checking bench for font_rom_arbiter: directed scenarios with literal
// expectations, a behavioural model compared every cycle, a return
// scoreboard and a latency monitor for the streaming requester.
module tb_font_rom_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [43:0] req_addr;
  logic [3:0]  pending;
  logic        rom_en;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rd_valid;
  logic [7:0]  rd_data;
  logic [3:0]  overrun;

  font_rom_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .pending  (pending),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .overrun  (overrun)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ROM model ----------------
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return ~a[7:0];
  endfunction

  initial rom_data = 8'h00;
  always @(posedge clk) if (rom_en) rom_data <= rom_fn(rom_addr);

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  m_pend = '0;
  logic [3:0]  m_ovr  = '0;
  logic [10:0] m_aq [4];
  int          m_ptr  = 0;
  int          m_tag  = 0;
  logic        m_en   = 1'b0;
  logic [10:0] m_addr = '0;
  logic [3:0]  m_rv   = '0;
  logic [7:0]  m_rd   = '0;
  logic [11:0] exp_q [$];

  always @(posedge clk) begin
    logic [3:0] np;
    int sel;
    bit found;
    if (reset) begin
      m_pend <= '0;
      m_ovr  <= '0;
      m_ptr  <= 0;
      m_tag  <= 0;
      m_en   <= 1'b0;
      m_addr <= '0;
      m_rv   <= '0;
      m_rd   <= '0;
      exp_q.delete();
    end else begin
      m_rv <= m_en ? 4'(1 << m_tag) : 4'b0000;
      if (m_en) m_rd <= rom_fn(m_addr);
      found = 1'b0;
      sel   = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && m_pend[(m_ptr + k) % 4]) begin
          found = 1'b1;
          sel   = (m_ptr + k) % 4;
        end
      end
      np = m_pend;
      if (found) begin
        np[sel] = 1'b0;
        m_en   <= 1'b1;
        m_addr <= m_aq[sel];
        m_tag  <= sel;
        m_ptr  <= (sel + 1) % 4;
        exp_q.push_back({4'(1 << sel), rom_fn(m_aq[sel])});
      end else begin
        m_en <= 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if (m_pend[i]) m_ovr[i] <= 1'b1;
          else begin
            np[i]   = 1'b1;
            m_aq[i] <= req_addr[i*11 +: 11];
          end
        end
      end
      m_pend <= np;
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  always @(negedge clk) begin
    logic [11:0] item;
    if (started) begin
      check("model_pending", {28'd0, pending}, {28'd0, m_pend});
      check("model_rom_en", {31'd0, rom_en}, {31'd0, m_en});
      if (m_en) check("model_rom_addr", {21'd0, rom_addr}, {21'd0, m_addr});
      check("model_rd_valid", {28'd0, rd_valid}, {28'd0, m_rv});
      if (m_rv != 4'b0000) check("model_rd_data", {24'd0, rd_data}, {24'd0, m_rd});
      check("model_overrun", {28'd0, overrun}, {28'd0, m_ovr});
      if (rd_valid != 4'b0000) begin
        if (exp_q.size() == 0) check("sb_spurious_rd_valid", {28'd0, rd_valid}, 32'd0);
        else begin
          item = exp_q.pop_front();
          check("sb_return", {20'd0, rd_valid, rd_data}, {20'd0, item});
        end
      end
    end
  end

  // ---------------- streaming latency monitor ----------------
  int lat_q [$];
  int n_stream = 0;
  always @(negedge clk) begin
    int t;
    if (started && rd_valid[1] && lat_q.size() > 0) begin
      t = lat_q.pop_front();
      n_stream++;
      check("stream_latency", cyc - t, 3);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Drive one request cycle, return at the next negedge with req cleared.
  task automatic drive(input logic [3:0] mask, input logic [10:0] a0, input logic [10:0] a1,
                       input logic [10:0] a2, input logic [10:0] a3);
    req      = mask;
    req_addr = {a3, a2, a1, a0};
    tick();
    req = 4'b0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset    = 1'b1;
    req      = 4'b0000;
    req_addr = '0;
    repeat (3) tick();
    started = 1'b1;
    check("rst_pending", {28'd0, pending}, 32'd0);
    check("rst_rom_en", {31'd0, rom_en}, 32'd0);
    check("rst_rom_addr", {21'd0, rom_addr}, 32'd0);
    check("rst_rd_valid", {28'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_overrun", {28'd0, overrun}, 32'd0);
    reset = 1'b0;
    tick();

    // Single request: 3 clk latency.
    drive(4'b0001, 11'h2A3, 11'h000, 11'h000, 11'h000);
    check("t1_pending", {28'd0, pending}, 32'h1);
    tick();
    check("t1_rom_en", {31'd0, rom_en}, 32'h1);
    check("t1_rom_addr", {21'd0, rom_addr}, 32'h2A3);
    tick();
    check("t1_rd_valid", {28'd0, rd_valid}, 32'h1);
    check("t1_rd_data", {24'd0, rd_data}, 32'h5C);
    check("t1_overrun", {28'd0, overrun}, 32'h0);
    tick();

    // All four contending from pointer 0.
    do_reset();
    drive(4'b1111, 11'h010, 11'h020, 11'h030, 11'h040);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t2_rom_addr", {21'd0, rom_addr}, 32'((k + 1) * 16));
      if (k > 0) check("t2_rd_valid", {28'd0, rd_valid}, 32'(1 << (k - 1)));
      tick();
    end
    check("t2_rd_valid_last", {28'd0, rd_valid}, 32'h8);
    check("t2_rd_data_last", {24'd0, rd_data}, 32'hBF);
    check("t2_rom_en_idle", {31'd0, rom_en}, 32'h0);
    tick();

    // Rotation: pointer 0 -> 0 before 3.
    drive(4'b1001, 11'h100, 11'h000, 11'h000, 11'h130);
    tick();
    check("t3a_first", {21'd0, rom_addr}, 32'h100);
    tick();
    check("t3a_second", {21'd0, rom_addr}, 32'h130);
    repeat (2) tick();
    // Single issue of index 0 moves pointer to 1.
    drive(4'b0001, 11'h155, 11'h000, 11'h000, 11'h000);
    repeat (3) tick();
    // Pointer 1 -> 3 before 0.
    drive(4'b1001, 11'h101, 11'h000, 11'h000, 11'h131);
    tick();
    check("t3c_first", {21'd0, rom_addr}, 32'h131);
    tick();
    check("t3c_second", {21'd0, rom_addr}, 32'h101);
    repeat (3) tick();

    // Overrun on requester 2.
    drive(4'b0100, 11'h000, 11'h000, 11'h111, 11'h000);
    req      = 4'b0100;
    req_addr = {11'h000, 11'h222, 11'h000, 11'h000};
    tick();
    req = 4'b0000;
    check("t4_rom_addr", {21'd0, rom_addr}, 32'h111);
    check("t4_overrun", {28'd0, overrun}, 32'h4);
    tick();
    check("t4_rd_valid", {28'd0, rd_valid}, 32'h4);
    check("t4_rd_data", {24'd0, rd_data}, 32'hEE);
    tick();
    check("t4_no_second_issue", {31'd0, rom_en}, 32'h0);
    tick();
    drive(4'b0100, 11'h000, 11'h000, 11'h333, 11'h000);
    tick();
    check("t4_fresh_addr", {21'd0, rom_addr}, 32'h333);
    tick();
    check("t4_fresh_rd_data", {24'd0, rd_data}, 32'hCC);
    check("t4_overrun_sticky", {28'd0, overrun}, 32'h4);
    tick();

    // Reset while the first read is on the ROM port.
    drive(4'b1111, 11'h011, 11'h022, 11'h033, 11'h044);
    tick();
    check("t5_rom_en_before", {31'd0, rom_en}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_pending", {28'd0, pending}, 32'h0);
    check("t5_rom_en", {31'd0, rom_en}, 32'h0);
    check("t5_rd_valid", {28'd0, rd_valid}, 32'h0);
    check("t5_overrun", {28'd0, overrun}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t5_quiet_rd_valid", {28'd0, rd_valid}, 32'h0);
    end

    // Continuous streaming on requester 1, one request every 4 clk.
    for (int i = 0; i < 250; i++) begin
      lat_q.push_back(cyc);
      drive(4'b0010, 11'h000, 11'(i * 37 + 5), 11'h000, 11'h000);
      repeat (3) tick();
    end
    repeat (3) tick();
    check("t6_returns", n_stream, 250);
    check("t6_lat_q_drained", lat_q.size(), 0);
    check("t6_overrun", {28'd0, overrun}, 32'h0);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
